i2s_tx: RTL and testbench
=========================

# i2s_tx

Stereo I2S transmitter: accepts 16-bit left/right sample pairs over a valid/ready handshake and serialises them as a standard Philips I2S stream for an external DAC/amplifier. It is the output-side counterpart of the mic `i2s` receivers, runs in the 98.3 MHz audio clock domain, and sits after the processing chain in place of, or alongside, `pdm`. With default parameters, BCLK is 3.072 MHz and the frame rate is 48 kHz, one frame every 2048 clocks.

## Interface
Parameters:
- CLK_DIV, 16: clk_in cycles per BCLK half-period; must be ≥ 2.
- SAMPLE_WIDTH, 16: bits per channel sample; must be ≤ 32.

Ports:
- clk_in  input  1  audio clock (98.3 MHz); all logic on posedge.
- rst_in_n  input  1  synchronous, active-low reset.
- left_in  input  SAMPLE_WIDTH  signed left sample.
- right_in  input  SAMPLE_WIDTH  signed right sample.
- valid_in  input  1  sample pair valid.
- ready_out  output  1  holding register empty; pair accepted when valid_in & ready_out.
- i2s_bclk_out  output  1  bit clock.
- i2s_lrclk_out  output  1  word select; 0 = left, 1 = right.
- i2s_data_out  output  1  serial data, MSB first.
- frame_load_out  output  1  one-cycle pulse when a frame is loaded into the shifter.
- underrun_out  output  1  one-cycle pulse when a load finds the holding register empty.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. At the terminal count:
  - If bclk = 0, bclk goes to 1 (rise event).
  - If bclk = 1, bclk goes to 0 (fall event).
- Slot counter bit_cnt (6 bits, 0..63) increments on each fall event and wraps 63→0.
- Only fall events update lrclk and data. After a fall into slot b:
  - lrclk = 1 for b in 31..62; lrclk = 0 for b = 63 and b in 0..30. This gives the standard one-BCLK I2S delay.
  - data = left[SW-1-b] for b < SW, where SW = SAMPLE_WIDTH.
  - data = right[SW-1-(b-32)] for 32 ≤ b < 32+SW.
  - data = 0 for all other slots.
- Holding register: one stereo pair plus a full flag. ready_out = !full, combinational from the flag.
  - An accept (valid_in & ready_out) sets full.
- Load occurs on the fall event 62→63:
  - full = 1: the shifter takes the held pair and full is cleared.
  - full = 0: underrun_out pulses and the shifter takes the underrun value (see Configuration).
  - frame_load_out pulses on every load.
- Load and accept in the same cycle: impossible, because ready_out = 0 whenever full = 1. A newly freed slot is accepted from the next cycle.
- Reset values, applied on the cycle after rst_in_n is sampled low:
  - div_cnt = 0, bclk = 0, bit_cnt = 63, lrclk = 0, data = 0.
  - shifter = 0, full = 0.
  - ready_out = 1, frame_load_out = 0, underrun_out = 0.
- Reset mid-frame aborts the frame immediately. A pending held pair is discarded.
- The first frame after reset is all zeros. Its first load happens at that frame's 62→63 fall event.

## Timing
- BCLK period: 2·CLK_DIV cycles.
  - First rise is registered at cycle CLK_DIV-1 after reset release.
  - First fall is registered at cycle 2·CLK_DIV-1.
- Frame period: 128·CLK_DIV cycles (2048 with the default).
- data and lrclk change only on the cycle bclk falls. The receiver samples on the rising BCLK edge, half a BCLK later.
- Latency: a pair accepted before a load reaches the shifter at that load. Its left MSB appears one BCLK later, at the fall into b = 0.
- Throughput: one pair per frame. ready_out stays low from accept until the next load.
- All outputs are registered, except ready_out, which comes combinationally from the full flag register.

## Configuration
- Macro I2S_TX_UNDERRUN_REPEAT_EN.
  - Defined: on underrun the shifter reloads the last transmitted pair (a zero pair if none since reset).
  - Undefined: on underrun the shifter loads zeros (mute).
- underrun_out pulses in both builds.

## Structure
- Package i2s_pkg holds:
  - localparams I2S_SLOT_BITS = 32 and I2S_FRAME_BITS = 64.
  - typedef stereo_sample_t: a packed struct of signed left and right fields.
- The package is shared with the receiver.
- Sub-module i2s_tx_clkgen contains the divider, bclk, bit_cnt and the rise/fall/load event strobes.
- The top-level i2s_tx contains the holding register, the shifter and lrclk/data generation.

## Test plan
- Idle after reset, valid_in = 0:
  - bclk period is 32 cycles and the lrclk period is 2048 cycles.
  - data stays 0.
  - underrun_out pulses once per frame, coincident with frame_load_out.
- Single pair L = 16'h8001, R = 16'h7FFE:
  - Bits captured on BCLK rises are L MSB-first starting one BCLK after lrclk falls, then 16 zeros.
  - R follows, starting one BCLK after lrclk rises.
- Back-to-back pairs A, B, C with valid_in held high:
  - ready_out drops after A and reasserts only the cycle after each load.
  - Frames are transmitted in order A, B, C with no underrun pulses.
- Starve after pair 16'h1234/16'h5678:
  - With the macro, the next frame repeats 1234/5678.
  - Without the macro, the next frame is all zeros.
  - underrun_out pulses once in both builds.
- Assert rst_in_n low at bit_cnt = 40 with a pair held:
  - Next cycle, all outputs hold their reset values and ready_out = 1.
  - The held pair is never transmitted.
- Run with CLK_DIV = 2: bclk period is 4 cycles, the frame is 256 cycles, and bit ordering is unchanged.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: frame geometry and stereo sample type shared by the I2S transmitter and receivers
package i2s_pkg;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_FRAME_BITS = 64;
  typedef struct packed {
    logic signed [I2S_SLOT_BITS-1:0] left;
    logic signed [I2S_SLOT_BITS-1:0] right;
  } stereo_sample_t;
  // Word select after a fall into slot b, including the one-BCLK Philips delay
  function automatic logic lrclk_for_slot(input logic [5:0] b);
    return (b >= 6'd31) && (b <= 6'd62);
  endfunction
endpackage

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen: BCLK divider, 64-slot counter and fall/load event strobes
module i2s_tx_clkgen #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  output logic       bclk_out,
  output logic       fall_out,
  output logic       load_out,
  output logic [5:0] next_bit_out
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic bclk_q, bclk_d, tc;
  always_comb begin
    tc = div_cnt_q == DW'(CLK_DIV - 1);
    fall_out = tc & bclk_q;
    load_out = fall_out & (bit_cnt_q == 6'd62);
    next_bit_out = bit_cnt_q + 6'd1;
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    bclk_d = tc ? ~bclk_q : bclk_q;
    bit_cnt_d = fall_out ? next_bit_out : bit_cnt_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      div_cnt_q <= '0;
      bclk_q <= 1'b0;
      bit_cnt_q <= 6'd63;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
  assign bclk_out = bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo Philips I2S transmitter with a one-pair holding register.
// I2S_TX_UNDERRUN_REPEAT_EN: on underrun resend the last pair instead of muting.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    frame_load_out,
  output logic                    underrun_out
);
  localparam logic [5:0] SW6 = 6'(SAMPLE_WIDTH);
  localparam logic [4:0] MSB5 = 5'(SAMPLE_WIDTH - 1);
  stereo_sample_t held_q, held_d, shift_q, shift_d;
  logic full_q, full_d, lrclk_q, lrclk_d, data_q, data_d;
  logic frame_load_q, frame_load_d, underrun_q, underrun_d;
  logic bclk, fall, load, accept, in_word;
  logic [5:0] next_bit;
  logic [4:0] idx;
  i2s_tx_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_in      (clk_in),
    .rst_in_n    (rst_in_n),
    .bclk_out    (bclk),
    .fall_out    (fall),
    .load_out    (load),
    .next_bit_out(next_bit)
  );
  always_comb begin
    accept = valid_in & ~full_q;
    held_d = accept ? stereo_sample_t'{left: I2S_SLOT_BITS'(signed'(left_in)),
                                       right: I2S_SLOT_BITS'(signed'(right_in))} : held_q;
    full_d = accept | (full_q & ~load);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    shift_d = (load & full_q) ? held_q : shift_q;
`else
    shift_d = load ? (full_q ? held_q : '0) : shift_q;
`endif
    // Left and right words share the same in-slot index; slot bit 5 picks the channel
    idx = MSB5 - next_bit[4:0];
    in_word = {1'b0, next_bit[4:0]} < SW6;
    lrclk_d = fall ? lrclk_for_slot(next_bit) : lrclk_q;
    data_d = fall ? (in_word & (next_bit[5] ? shift_q.right[idx] : shift_q.left[idx])) : data_q;
    frame_load_d = load;
    underrun_d = load & ~full_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      held_q <= '0;
      shift_q <= '0;
      full_q <= 1'b0;
      lrclk_q <= 1'b0;
      data_q <= 1'b0;
      frame_load_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      held_q <= held_d;
      shift_q <= shift_d;
      full_q <= full_d;
      lrclk_q <= lrclk_d;
      data_q <= data_d;
      frame_load_q <= frame_load_d;
      underrun_q <= underrun_d;
    end
  end
  assign ready_out = ~full_q;
  assign i2s_bclk_out = bclk;
  assign i2s_lrclk_out = lrclk_q;
  assign i2s_data_out = data_q;
  assign frame_load_out = frame_load_q;
  assign underrun_out = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx at CLK_DIV=16 plus a CLK_DIV=2 instance
module tb_i2s_tx;
  localparam int CD = 16;
  localparam int FP = 128 * CD;
  logic clk = 1'b0;
  logic rst_n = 1'b0, valid = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic ready, bclk, lrclk, data, fload, urun;
  logic rst2_n = 1'b0, valid2 = 1'b0;
  logic [15:0] left2 = '0, right2 = '0;
  logic ready2, bclk2, lrclk2, data2, fload2, urun2;
  int checks = 0, failures = 0;
  int cyc = -1, nloads = 0, nunder = 0, slot_cnt = -1;
  logic m_full = 1'b0;
  logic [15:0] m_l = '0, m_r = '0, last_l = '0, last_r = '0;
  logic [31:0] exp_q[$];
  logic prev_bclk = 1'b0, prev_lr = 1'b1, prev_dc = 1'b0, prev_lc = 1'b0;
  logic [62:0] cap_d = '0, cap_lr = '0;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(CD), .SAMPLE_WIDTH(16)) dut (
    .clk_in(clk), .rst_in_n(rst_n), .left_in(left), .right_in(right), .valid_in(valid),
    .ready_out(ready), .i2s_bclk_out(bclk), .i2s_lrclk_out(lrclk), .i2s_data_out(data),
    .frame_load_out(fload), .underrun_out(urun));

  i2s_tx #(.CLK_DIV(2), .SAMPLE_WIDTH(16)) dut2 (
    .clk_in(clk), .rst_in_n(rst2_n), .left_in(left2), .right_in(right2), .valid_in(valid2),
    .ready_out(ready2), .i2s_bclk_out(bclk2), .i2s_lrclk_out(lrclk2), .i2s_data_out(data2),
    .frame_load_out(fload2), .underrun_out(urun2));

  // Called on every falling clk edge, before new inputs are driven
  task automatic mon();
    logic acc, old_full;
    logic [31:0] e;
    if (!rst_n) begin
      cyc = -1; m_full = 1'b0; last_l = '0; last_r = '0;
      exp_q.delete(); exp_q.push_back('0);
      prev_bclk = 1'b0; prev_lr = 1'b1; prev_dc = 1'b0; prev_lc = 1'b0; slot_cnt = -1;
      return;
    end
    cyc++;
    acc = valid && !m_full;
    old_full = m_full;
    checks++;
    if (fload !== (cyc % FP == FP - 1)) begin
      failures++; $display("FAIL load_timing cyc=%0d got=%b", cyc, fload);
    end
    checks++;
    if (urun !== (fload && !old_full)) begin
      failures++; $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, urun, fload && !old_full);
    end
    if (fload) begin
      nloads++;
      if (old_full) begin
        exp_q.push_back({m_l, m_r}); last_l = m_l; last_r = m_r; m_full = 1'b0;
      end else begin
        nunder++;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        exp_q.push_back({last_l, last_r});
`else
        exp_q.push_back('0);
`endif
      end
    end
    if (acc) begin m_full = 1'b1; m_l = left; m_r = right; end
    checks++;
    if (ready !== !m_full) begin
      failures++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, !m_full);
    end
    checks++;
    if ((data !== prev_dc || lrclk !== prev_lc) && !(prev_bclk && !bclk)) begin
      failures++; $display("FAIL edge cyc=%0d data/lrclk changed without bclk fall", cyc);
    end
    if (bclk && !prev_bclk) begin
      if (prev_lr && !lrclk) slot_cnt = 0;
      else if (slot_cnt >= 0) slot_cnt++;
      if (slot_cnt >= 1 && slot_cnt <= 63) begin
        cap_d[63 - slot_cnt] = data; cap_lr[63 - slot_cnt] = lrclk;
      end
      if (slot_cnt == 63) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL frame_queue empty at cyc=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cap_d !== {e[31:16], 16'h0, e[15:0], 15'h0}) begin
            failures++; $display("FAIL frame_data got=%h exp=%h", cap_d, {e[31:16], 16'h0, e[15:0], 15'h0});
          end
        end
        checks++;
        if (cap_lr !== {31'h0, 32'hFFFF_FFFF}) begin
          failures++; $display("FAIL frame_lrclk got=%h", cap_lr);
        end
      end
      if (slot_cnt == 64) begin
        checks++; failures++; slot_cnt = -1;
        $display("FAIL lrclk_fall missing at cyc=%0d", cyc);
      end
      prev_lr = lrclk;
    end
    prev_bclk = bclk; prev_dc = data; prev_lc = lrclk;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic run_loads(input int n);
    int seen = 0;
    for (int c = 0; c < n * FP + 8 && seen < n; c++) begin
      tick();
      if (fload) seen++;
    end
    checks++;
    if (seen != n) begin failures++; $display("FAIL load_wait got=%0d exp=%0d", seen, n); end
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int c = 0;
    valid = 1'b1; left = l; right = r;
    while (!ready && c < 2 * FP) begin tick(); c++; end
    tick();
    valid = 1'b0;
    checks++;
    if (c >= 2 * FP) begin failures++; $display("FAIL send_timeout got=%0d", c); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (bclk !== 1'b0) begin failures++; $display("FAIL %s_bclk got=%b exp=0", tag, bclk); end
    checks++; if (lrclk !== 1'b0) begin failures++; $display("FAIL %s_lrclk got=%b exp=0", tag, lrclk); end
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL %s_data got=%b exp=0", tag, data); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", tag, ready); end
    checks++; if (fload !== 1'b0) begin failures++; $display("FAIL %s_fload got=%b exp=0", tag, fload); end
    checks++; if (urun !== 1'b0) begin failures++; $display("FAIL %s_underrun got=%b exp=0", tag, urun); end
  endtask

  task automatic test_reset();
    int r = -1, f = -1;
    rst_n = 1'b0; valid = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 4 * CD && f < 0; c++) begin
      tick();
      if (bclk && r < 0) r = cyc;
      if (r >= 0 && !bclk && f < 0) f = cyc;
    end
    checks++; if (r != CD - 1) begin failures++; $display("FAIL first_rise got=%0d exp=%0d", r, CD - 1); end
    checks++; if (f != 2 * CD - 1) begin failures++; $display("FAIL first_fall got=%0d exp=%0d", f, 2 * CD - 1); end
  endtask

  task automatic test_idle();
    int r0 = -1, r1 = -1, f0 = -1, f1 = -1, u0 = nunder, l0 = nloads;
    logic pb = bclk, pl = lrclk;
    valid = 1'b0;
    for (int c = 0; c < 3 * FP && f1 < 0; c++) begin
      tick();
      if (bclk && !pb) begin if (r0 < 0) r0 = cyc; else if (r1 < 0) r1 = cyc; end
      if (!lrclk && pl) begin if (f0 < 0) f0 = cyc; else f1 = cyc; end
      pb = bclk; pl = lrclk;
    end
    checks++; if (r1 - r0 != 2 * CD) begin failures++; $display("FAIL bclk_period got=%0d exp=%0d", r1 - r0, 2 * CD); end
    checks++; if (f1 - f0 != FP) begin failures++; $display("FAIL lrclk_period got=%0d exp=%0d", f1 - f0, FP); end
    checks++; if (nunder - u0 != 2) begin failures++; $display("FAIL idle_underruns got=%0d exp=2", nunder - u0); end
    checks++; if (nloads - l0 != 2) begin failures++; $display("FAIL idle_loads got=%0d exp=2", nloads - l0); end
  endtask

  task automatic test_single();
    int u0 = nunder;
    send(16'h8001, 16'h7FFE);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b exp=0", ready); end
    run_loads(1);
    checks++; if (nunder != u0) begin failures++; $display("FAIL single_underrun got=%0d exp=%0d", nunder, u0); end
    run_loads(1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ls[3] = '{16'hA11A, 16'hB22B, 16'hC33C};
    logic [15:0] rs[3] = '{16'h1AA1, 16'h2BB2, 16'h3CC3};
    int idx = 0, lds = 0, u0 = nunder;
    logic rb;
    valid = 1'b1; left = ls[0]; right = rs[0];
    for (int c = 0; c < 5 * FP && lds < 3; c++) begin
      rb = ready;
      tick();
      if (fload) begin
        lds++;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_load got=%b exp=1", ready); end
      end
      if (rb && idx < 3) begin
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_accept got=%b exp=0", ready); end
        idx++;
        if (idx < 3) begin left = ls[idx]; right = rs[idx]; end
        else valid = 1'b0;
      end
    end
    checks++; if (idx != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
    checks++; if (nunder != u0) begin failures++; $display("FAIL b2b_underrun got=%0d exp=%0d", nunder, u0); end
    run_loads(1);
  endtask

  task automatic test_starve();
    int u0 = nunder;
    send(16'h1234, 16'h5678);
    run_loads(1);
    checks++; if (nunder != u0) begin failures++; $display("FAIL starve_first got=%0d exp=%0d", nunder, u0); end
    run_loads(1);
    checks++; if (nunder != u0 + 1) begin failures++; $display("FAIL starve_underrun got=%0d exp=%0d", nunder, u0 + 1); end
    run_loads(1);
  endtask

  task automatic test_reset_mid();
    int c = 0, u0;
    send(16'hDEAD, 16'hBEEF);
    while (slot_cnt != 41 && c < 2 * FP) begin tick(); c++; end
    checks++; if (slot_cnt != 41) begin failures++; $display("FAIL mid_slot got=%0d exp=41", slot_cnt); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_held got=%b exp=0", ready); end
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    u0 = nunder;
    run_loads(2);
    checks++; if (nunder != u0 + 2) begin failures++; $display("FAIL mid_discard got=%0d exp=%0d", nunder, u0 + 2); end
  endtask

  task automatic test_clkdiv2();
    int r0 = -1, r1 = -1, l0 = -1, l1 = -1, k = -1;
    logic pb;
    logic [63:0] wd = '0, wl = '0;
    rst2_n = 1'b0;
    tick(); tick();
    rst2_n = 1'b1; valid2 = 1'b1; left2 = 16'hC35A; right2 = 16'h0F96;
    pb = bclk2;
    for (int c = 0; c < 1000 && l1 < 0; c++) begin
      tick();
      if (c == 0) begin
        valid2 = 1'b0;
        checks++; if (ready2 !== 1'b0) begin failures++; $display("FAIL div2_ready got=%b exp=0", ready2); end
      end
      if (bclk2 && !pb) begin
        if (r0 < 0) r0 = c; else if (r1 < 0) r1 = c;
        if (k >= 0 && k < 64) begin wd[63 - k] = data2; wl[63 - k] = lrclk2; k++; end
      end
      if (fload2) begin
        if (l0 < 0) begin
          l0 = c; k = 0;
          checks++; if (urun2 !== 1'b0) begin failures++; $display("FAIL div2_underrun1 got=%b exp=0", urun2); end
        end else begin
          l1 = c;
          checks++; if (urun2 !== 1'b1) begin failures++; $display("FAIL div2_underrun2 got=%b exp=1", urun2); end
        end
      end
      pb = bclk2;
    end
    checks++; if (r1 - r0 != 4) begin failures++; $display("FAIL div2_bclk_period got=%0d exp=4", r1 - r0); end
    checks++; if (l0 != 255) begin failures++; $display("FAIL div2_first_load got=%0d exp=255", l0); end
    checks++; if (l1 - l0 != 256) begin failures++; $display("FAIL div2_frame got=%0d exp=256", l1 - l0); end
    checks++;
    if (wd !== {1'b0, 16'hC35A, 16'h0, 16'h0F96, 15'h0}) begin
      failures++; $display("FAIL div2_bits got=%h exp=%h", wd, {1'b0, 16'hC35A, 16'h0, 16'h0F96, 15'h0});
    end
    checks++; if (wl !== {32'h0, 32'hFFFF_FFFF}) begin failures++; $display("FAIL div2_lrclk got=%h", wl); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    test_clkdiv2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
